// File: rtl/inst_fetch.sv
// Instruction fetch unit: streams sequential ROM words into a small prefetch queue,
// with a redirect input that flushes the queue and restarts fetching at a new address.
module inst_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    output logic        rom_chip_enable,
    input  logic [31:0] rom_data,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic [3:0]  queue_count
);

    localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     fetch_pc;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [3:0]      count;
    logic            push;
    logic            pop;
    logic            redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full queue can still fetch
    // when the head is being accepted.
    always_comb begin
        rom_chip_enable = 1'b0;
        if (state == RUN && !branch_flag && (count < DEPTH_CNT || pop)) begin
            rom_chip_enable = 1'b1;
        end
    end

    assign redirect   = (state == RUN) && branch_flag;
    assign inst_valid = (count != 4'd0);
    assign pop        = inst_valid && !stall && !redirect;
    assign push       = rom_chip_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {branch_target[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= rom_data;
        end
    end

    assign rom_addr    = fetch_pc;
    assign queue_count = count;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;
    assign inst_data   = inst_valid ? data_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a long randomized
// stall/redirect run, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] rom_addr;
    logic        rom_chip_enable;
    logic [31:0] rom_data;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic [3:0]  queue_count;

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, next fetch address, queue of fetched addresses.
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_chip_enable(rom_chip_enable),
        .rom_data       (rom_data),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .queue_count    (queue_count)
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Word n holds n; garbage when not enabled so an unqualified push is visible.
    assign rom_data = rom_chip_enable ? rom_fn(rom_addr) : 32'hDEAD_BEEF;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic m_ce();
        int n;
        n = m_q.size();
        return m_run && !branch_flag && (n < DEPTH || (n != 0 && !stall));
    endfunction

    function automatic logic [31:0] m_head_pc();
        return (m_q.size() != 0) ? m_q[0] : 32'h0;
    endfunction

    function automatic logic [31:0] m_head_data();
        return (m_q.size() != 0) ? rom_fn(m_q[0]) : 32'h0;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RESET_PC;
        m_q.delete();
    endtask

    task automatic model_edge();
        int n;
        bit do_pop;
        bit do_push;
        if (reset) return;
        if (!m_run) begin
            m_run = 1'b1;
            return;
        end
        if (branch_flag) begin
            m_q.delete();
            m_pc = {branch_target[31:2], 2'b00};
            return;
        end
        n       = m_q.size();
        do_pop  = (n != 0) && !stall;
        do_push = (n < DEPTH) || do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        branch_flag   = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (rom_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h required %h", rom_addr, RESET_PC); end
        checks++; if (rom_chip_enable !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b required 0", rom_chip_enable); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", inst_valid); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", inst_pc); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", inst_data); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", queue_count); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (rom_chip_enable !== 1'b0 || queue_count !== 4'd0) begin errors++; $display("FAIL reset_held: ce %b count %0d required 0 0", rom_chip_enable, queue_count); end
        reset         = 1'b0;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0040;
        #1;
        checks++; if (rom_chip_enable !== 1'b0) begin errors++; $display("FAIL idle_ce: got %b required 0", rom_chip_enable); end
        step();
        branch_flag = 1'b0;
        #1;
        checks++; if (rom_addr !== RESET_PC) begin errors++; $display("FAIL idle_branch_ignored: got %h required %h", rom_addr, RESET_PC); end
        checks++; if (rom_chip_enable !== 1'b1) begin errors++; $display("FAIL first_fetch_ce: got %b required 1", rom_chip_enable); end
    endtask

    task automatic test_sequential();
        do_reset();
        step();
        checks++; if (rom_chip_enable !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("FAIL seq_cycle1: ce %b addr %h required 1 00000000", rom_chip_enable, rom_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_cycle1_valid: got %b required 0", inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL seq_cycle2: valid %b pc %h data %h required 1 0 0", inst_valid, inst_pc, inst_data); end
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++; if (inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc: got %h required %h", inst_pc, 32'(4 * i)); end
            checks++; if (inst_data !== 32'(i)) begin errors++; $display("FAIL seq_data: got %h required %h", inst_data, 32'(i)); end
            checks++; if (queue_count !== 4'(m_q.size())) begin errors++; $display("FAIL seq_count: got %0d required %0d", queue_count, m_q.size()); end
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        stall = 1'b1;
        repeat (6) step();
        checks++; if (queue_count !== 4'd4) begin errors++; $display("FAIL fill_count: got %0d required 4", queue_count); end
        checks++; if (rom_chip_enable !== 1'b0) begin errors++; $display("FAIL fill_ce: got %b required 0", rom_chip_enable); end
        checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL fill_addr: got %h required 00000010", rom_addr); end
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL drain_pc: valid %b pc %h required 1 %h", inst_valid, inst_pc, 32'(4 * i)); end
            checks++; if (queue_count !== 4'd4) begin errors++; $display("FAIL drain_count: got %0d required 4", queue_count); end
            step();
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        step();
        checks++; if (queue_count !== 4'd4) begin errors++; $display("FAIL redir_full: got %0d required 4", queue_count); end
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0103;
        #1;
        checks++; if (rom_chip_enable !== 1'b0) begin errors++; $display("FAIL redir_ce: got %b required 0", rom_chip_enable); end
        step();
        branch_flag = 1'b0;
        #1;
        checks++; if (queue_count !== 4'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: count %0d valid %b required 0 0", queue_count, inst_valid); end
        checks++; if (rom_addr !== 32'h100 || rom_chip_enable !== 1'b1) begin errors++; $display("FAIL redir_fetch: addr %h ce %b required 00000100 1", rom_addr, rom_chip_enable); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h40) begin errors++; $display("FAIL redir_head: valid %b pc %h data %h required 1 00000100 00000040", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8;
        exp_seq[1] = 32'hFFFF_FFFC;
        exp_seq[2] = 32'h0000_0000;
        stall         = 1'b0;
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        step();
        branch_flag = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_seq[i]) begin errors++; $display("FAIL wrap_pc: valid %b pc %h required 1 %h", inst_valid, inst_pc, exp_seq[i]); end
            checks++; if (inst_data !== rom_fn(exp_seq[i])) begin errors++; $display("FAIL wrap_data: got %h required %h", inst_data, rom_fn(exp_seq[i])); end
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        repeat (4) step();
        checks++; if (queue_count !== 4'd3) begin errors++; $display("FAIL areset_pre_count: got %0d required 3", queue_count); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (rom_addr !== RESET_PC || rom_chip_enable !== 1'b0) begin errors++; $display("FAIL areset_rom: addr %h ce %b required %h 0", rom_addr, rom_chip_enable, RESET_PC); end
        checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL areset_inst: valid %b pc %h data %h required 0 0 0", inst_valid, inst_pc, inst_data); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d required 0", queue_count); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (rom_chip_enable !== 1'b0) begin errors++; $display("FAIL areset_idle_ce: got %b required 0", rom_chip_enable); end
        step();
        checks++; if (rom_chip_enable !== 1'b1 || rom_addr !== RESET_PC) begin errors++; $display("FAIL areset_recover: ce %b addr %h required 1 %h", rom_chip_enable, rom_addr, RESET_PC); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin errors++; $display("FAIL areset_first_inst: valid %b pc %h required 1 %h", inst_valid, inst_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        do_reset();
        exp_next = RESET_PC;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            stall         = ($urandom_range(0, 99) < 45);
            branch_flag   = ($urandom_range(0, 299) == 0);
            branch_target = $urandom();
            #1;
            checks++; if (rom_chip_enable !== m_ce()) begin errors++; $display("FAIL rnd_ce @%0d: got %b required %b", cyc, rom_chip_enable, m_ce()); end
            checks++; if (rom_addr !== m_pc) begin errors++; $display("FAIL rnd_addr @%0d: got %h required %h", cyc, rom_addr, m_pc); end
            checks++; if (queue_count !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d required %0d", cyc, queue_count, m_q.size()); end
            checks++; if (inst_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b required %b", cyc, inst_valid, m_q.size() != 0); end
            checks++; if (inst_pc !== m_head_pc() || inst_data !== m_head_data()) begin errors++; $display("FAIL rnd_head @%0d: pc %h data %h required %h %h", cyc, inst_pc, inst_data, m_head_pc(), m_head_data()); end
            if (m_run && branch_flag) begin
                exp_next = {branch_target[31:2], 2'b00};
            end else if (m_run && m_q.size() != 0 && !stall) begin
                checks++; if (inst_pc !== exp_next) begin errors++; $display("FAIL rnd_accept_seq @%0d: got %h required %h", cyc, inst_pc, exp_next); end
                exp_next = exp_next + 32'd4;
            end
            step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        branch_flag   = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall_fill();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rom_addr  out  32  instruction ROM byte address.
REQ-006 SHALL have port rom_chip_enable  out  1  ROM read enable.
REQ-007 SHALL have port rom_data  in  32  ROM word; valid in the same cycle rom_addr is driven with rom_chip_enable=1 (combinational ROM).
REQ-008 SHALL have port branch_flag  in  1  redirect request from the execute stage.
REQ-009 SHALL have port branch_target  in  32  redirect address.
REQ-010 SHALL have port stall  in  1  downstream decode not ready to accept.
REQ-011 SHALL have port inst_valid  out  1  queue head valid.
REQ-012 SHALL have port inst_pc  out  32  address of the queue-head instruction.
REQ-013 SHALL have port inst_data  out  32  queue-head instruction word.
REQ-014 SHALL have port queue_count  out  4  current queue occupancy, 0..DEPTH.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; reset forces IDLE; IDLE -> RUN unconditionally after one clock; RUN persists until reset.
REQ-016 SHALL drive rom_chip_enable=0 in IDLE.
REQ-017 SHALL hold internal register fetch_pc and drive rom_addr = fetch_pc at all times.
REQ-018 In RUN, SHALL assert rom_chip_enable when branch_flag=0 and (queue_count<DEPTH or a pop occurs in the same cycle).
REQ-019 Push: when rom_chip_enable=1, SHALL write {fetch_pc, rom_data} into the queue tail and set fetch_pc <= fetch_pc+4.
REQ-020 fetch_pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-021 Pop: SHALL occur when inst_valid=1 and stall=0; the head entry is discarded at the clock edge.
REQ-022 inst_valid SHALL equal (queue_count!=0); inst_pc/inst_data SHALL show the head entry, and 0 when empty.
REQ-023 Simultaneous push and pop SHALL leave queue_count unchanged, including at full and at count=1.
REQ-024 A pushed instruction SHALL first be visible on inst_* the cycle after its fetch (1-cycle latency when empty).
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; no entry SHALL be lost or duplicated across wrap.
REQ-026 Full (count=DEPTH) with stall=1: no push, fetch_pc holds, rom_chip_enable=0.
REQ-027 Redirect: branch_flag=1 in RUN SHALL, at the edge, empty the queue (count=0), discard any pop, and set fetch_pc <= {branch_target[31:2], 2'b00}.
REQ-028 branch_flag SHALL take priority over stall and over any push/pop in the same cycle.
REQ-029 branch_flag in IDLE SHALL be ignored.
REQ-030 The first fetch after a redirect SHALL occur the following cycle at the aligned target.

Reset
REQ-031 While reset=1, outputs SHALL be: rom_addr=RESET_PC, rom_chip_enable=0, inst_valid=0, inst_pc=0, inst_data=0, queue_count=0, independent of clock.
REQ-032 Reset assertion mid-operation SHALL immediately discard all queue contents and return to IDLE with fetch_pc=RESET_PC.
REQ-033 First ROM read after reset deassertion SHALL be at RESET_PC, exactly one clock after IDLE.

Verification
REQ-034 Reset release, stall=0, ROM word n = n: -> cycle 1 rom_chip_enable=1, rom_addr=0; cycle 2 inst_valid=1, inst_pc=0, inst_data=0; thereafter inst_pc advances by 4 each cycle.
REQ-035 stall=1 held for 6 cycles from reset -> queue_count reaches 4, rom_chip_enable=0, fetch_pc=0x10; release -> inst_pc 0x0,0x4,0x8,0xC then 0x10 with no gap.
REQ-036 Queue full, branch_flag=1, branch_target=0x0000_0103 with stall=1 -> next cycle queue_count=0, inst_valid=0; following cycle rom_addr=0x100, then inst_pc=0x100.
REQ-037 Start with fetch_pc forced via redirect to 0xFFFF_FFF8, stall=0 -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 Reset asserted asynchronously between edges with count=3 -> all outputs at REQ-031 values before the next edge; recovery per REQ-033.
REQ-039 Random stall pattern over 10,000 cycles with scoreboard -> inst_pc strictly sequential (+4) per accepted instruction, no loss or duplication across pointer wrap.
